// File: rtl/test_wr_ctrl_128bit_pkg.sv
// Shared definitions for the DDR3 example-design AXI test controllers:
// state encoding, AXI constants and the data-pattern LFSR.
package test_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } ctrl_state_t;

    localparam logic [2:0] SIZE_16B   = 3'b100;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // x^8+x^6+x^5+x^4+1, shifting left; taps are state bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int NUM_LANES = 8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/test_wr_ctrl_128bit_if.sv
// AXI write address/data/response channels of the 128-bit test port.
interface test_wr_ctrl_128bit_if;
    logic [31:0]  awaddr;
    logic [7:0]   awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic         awurgent;
    logic         awpoison;
    logic [3:0]   awqos;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awlock, awurgent, awpoison, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awlock, awurgent, awpoison, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/test_wr_ctrl_128bit_lfsr8.sv
// 8-bit Fibonacci LFSR supplying the per-beat pattern byte; advances only on adv.
module test_wr_lfsr8
    import test_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end
endmodule

// File: rtl/test_wr_ctrl_128bit.sv
// AXI write traffic generator for DDR3 self-test: one INCR burst per write_en.
// Optional response checking is built when TEST_WR_BRESP_CHK_EN is defined.
module test_wr_ctrl_128bit
    import test_ctrl_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 16,
    parameter int MEM_SPACE_AW    = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
    input  logic [3:0]                 random_axi_id,
    input  logic [3:0]                 random_axi_len,
    input  logic                       write_en,
    input  logic                       data_pattern_01,
    output logic                       write_done_p,
    output logic [7:0]                 wr_err_cnt,
    test_wr_ctrl_128bit_if.master      axi
);
    localparam int DATA_W = NUM_LANES * MEM_DQ_WIDTH;

    ctrl_state_t        state_reg;
    logic [31:0]        awaddr_reg;
    logic [7:0]         awid_reg;
    logic [7:0]         awlen_reg;
    logic               awvalid_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [DATA_W-1:0]  wdata_next;
    logic               wlast_reg;
    logic               wvalid_reg;
    logic [7:0]         beat_cnt_reg;
    logic [7:0]         beat_addr_reg;
    logic               done_reg;
    logic [7:0]         lfsr_q;
    logic               w_hs;
    logic [7:0]         pat_r;
    logic [7:0]         pat_base;

    assign w_hs = (state_reg == ST_W) && wvalid_reg && axi.wready;

    test_wr_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (w_hs),
        .q   (lfsr_q)
    );

    // In IDLE the first beat uses the current LFSR value and start address;
    // in W the following beat uses the post-advance value and the next address.
    always_comb begin
        pat_r    = lfsr_q;
        pat_base = random_rw_addr[7:0];
        if (state_reg == ST_W) begin
            pat_r    = lfsr_step(lfsr_q);
            pat_base = beat_addr_reg + 8'd8;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign wdata_next[gi*MEM_DQ_WIDTH +: MEM_DQ_WIDTH] = data_pattern_01
                ? ((gi % 2 == 0) ? 16'hFFFF : 16'h0000)
                : {pat_r, pat_r ^ (pat_base + 8'(gi))};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            awaddr_reg    <= '0;
            awid_reg      <= '0;
            awlen_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wdata_reg     <= '0;
            wlast_reg     <= 1'b0;
            wvalid_reg    <= 1'b0;
            beat_cnt_reg  <= '0;
            beat_addr_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (write_en) begin
                        awaddr_reg    <= 32'({random_rw_addr, 1'b0});
                        awid_reg      <= {4'b0000, random_axi_id};
                        awlen_reg     <= {4'b0000, random_axi_len};
                        beat_addr_reg <= random_rw_addr[7:0];
                        beat_cnt_reg  <= '0;
                        wdata_reg     <= wdata_next;
                        awvalid_reg   <= 1'b1;
                        state_reg     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (axi.awready) begin
                        awvalid_reg <= 1'b0;
                        wvalid_reg  <= 1'b1;
                        wlast_reg   <= (awlen_reg == 8'd0);
                        state_reg   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        beat_cnt_reg  <= beat_cnt_reg + 8'd1;
                        beat_addr_reg <= beat_addr_reg + 8'd8;
                        wdata_reg     <= wdata_next;
                        if (wlast_reg) begin
                            wvalid_reg <= 1'b0;
                            wlast_reg  <= 1'b0;
                            state_reg  <= ST_B;
                        end else begin
                            wlast_reg <= (beat_cnt_reg + 8'd1 == awlen_reg);
                        end
                    end
                end
                ST_B: begin
                    if (axi.bvalid) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef TEST_WR_BRESP_CHK_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if ((state_reg == ST_B) && axi.bvalid &&
                     ((axi.bresp != 2'b00) || (axi.bid != awid_reg)) &&
                     (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign wr_err_cnt = err_cnt_reg;
    wire unused_ok = (MEM_SPACE_AW != 0);
`else
    assign wr_err_cnt = 8'h00;
    wire unused_ok = &{1'b0, axi.bid, axi.bresp, (MEM_SPACE_AW != 0)};
`endif

    assign write_done_p = done_reg;
    assign axi.awaddr   = awaddr_reg;
    assign axi.awid     = awid_reg;
    assign axi.awlen    = awlen_reg;
    assign axi.awsize   = SIZE_16B;
    assign axi.awburst  = BURST_INCR;
    assign axi.awlock   = 1'b0;
    assign axi.awurgent = 1'b0;
    assign axi.awpoison = 1'b0;
    assign axi.awqos    = 4'h0;
    assign axi.awvalid  = awvalid_reg;
    assign axi.wdata    = wdata_reg;
    assign axi.wstrb    = '1;
    assign axi.wlast    = wlast_reg;
    assign axi.wvalid   = wvalid_reg;
    assign axi.bready   = 1'b1;

endmodule

// File: tb/tb_test_wr_ctrl_128bit.sv
// Directed self-checking bench for test_wr_ctrl_128bit (honours TEST_WR_BRESP_CHK_EN).
module tb_test_wr_ctrl_128bit;
    logic        clk;
    logic        rst;
    logic [27:0] random_rw_addr;
    logic [3:0]  random_axi_id;
    logic [3:0]  random_axi_len;
    logic        write_en;
    logic        data_pattern_01;
    logic        write_done_p;
    logic [7:0]  wr_err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] beat_data [16];
    logic         beat_last [16];

    test_wr_ctrl_128bit_if axi();

    test_wr_ctrl_128bit dut (
        .clk             (clk),
        .rst             (rst),
        .random_rw_addr  (random_rw_addr),
        .random_axi_id   (random_axi_id),
        .random_axi_len  (random_axi_len),
        .write_en        (write_en),
        .data_pattern_01 (data_pattern_01),
        .write_done_p    (write_done_p),
        .wr_err_cnt      (wr_err_cnt),
        .axi             (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; write_en = 1'b0; data_pattern_01 = 1'b0;
        random_rw_addr = '0; random_axi_id = '0; random_axi_len = '0;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
        axi.bid = '0; axi.bresp = 2'b00;
        step; step;
        rst = 1'b0;
    endtask

    // Drives one burst and records the accepted beats; checks are made by the callers.
    task automatic run_burst(input logic [27:0] a, input logic [3:0] id, input logic [3:0] len,
                             input logic pat, input bit toggle, input logic [1:0] resp,
                             output int nb, output int stall_bad, output int cyc, output bit to);
        logic hs, stall, l0;
        logic [127:0] d0;
        nb = 0; stall_bad = 0; cyc = 1; to = 1'b0;
        random_rw_addr = a; random_axi_id = id; random_axi_len = len; data_pattern_01 = pat;
        axi.bid = {4'h0, id}; axi.bresp = resp; axi.bvalid = 1'b0;
        axi.awready = 1'b1; axi.wready = 1'b1;
        write_en = 1'b1;
        step;
        write_en = 1'b0;
        while (write_done_p !== 1'b1 && !to) begin
            if (toggle) axi.wready = ~axi.wready;
            hs = axi.wvalid & axi.wready;
            stall = axi.wvalid & ~axi.wready;
            d0 = axi.wdata;
            l0 = axi.wlast;
            if (hs) begin
                if (nb < 16) begin beat_data[nb] = d0; beat_last[nb] = l0; end
                nb++;
            end
            step;
            cyc++;
            if (stall && (axi.wdata !== d0 || axi.wlast !== l0 || axi.wvalid !== 1'b1)) stall_bad++;
            if (hs && l0) axi.bvalid = 1'b1;
            if (cyc > 200) to = 1'b1;
        end
        axi.bvalid = 1'b0;
        axi.wready = 1'b1;
        $display("burst addr=%h id=%0d len=%0d pat=%0d beats=%0d cycles=%0d err_cnt=%h",
                 a, id, len, pat, nb, cyc, wr_err_cnt);
    endtask

    task automatic test_reset;
        do_reset;
        rst = 1'b1;
        step;
        n_cmp++; if (axi.awvalid !== 1'b0) begin n_bad++; $display("FAIL reset_awvalid: got %b want 0", axi.awvalid); end
        n_cmp++; if (axi.wvalid !== 1'b0) begin n_bad++; $display("FAIL reset_wvalid: got %b want 0", axi.wvalid); end
        n_cmp++; if (axi.wlast !== 1'b0) begin n_bad++; $display("FAIL reset_wlast: got %b want 0", axi.wlast); end
        n_cmp++; if (axi.wdata !== 128'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", axi.wdata); end
        n_cmp++; if (axi.awaddr !== 32'h0) begin n_bad++; $display("FAIL reset_awaddr: got %h want 0", axi.awaddr); end
        n_cmp++; if (write_done_p !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", write_done_p); end
        n_cmp++; if (wr_err_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_errcnt: got %h want 00", wr_err_cnt); end
        n_cmp++; if (axi.awsize !== 3'b100) begin n_bad++; $display("FAIL awsize: got %b want 100", axi.awsize); end
        n_cmp++; if (axi.awburst !== 2'b01) begin n_bad++; $display("FAIL awburst: got %b want 01", axi.awburst); end
        n_cmp++; if (axi.wstrb !== 16'hFFFF) begin n_bad++; $display("FAIL wstrb: got %h want ffff", axi.wstrb); end
        n_cmp++; if (axi.bready !== 1'b1) begin n_bad++; $display("FAIL bready: got %b want 1", axi.bready); end
        rst = 1'b0;
    endtask

    task automatic test_single_beat;
        do_reset;
        random_rw_addr = 28'h10; random_axi_id = 4'd3; random_axi_len = 4'd0;
        axi.bid = 8'h03; axi.bresp = 2'b00;
        write_en = 1'b1;
        step;
        write_en = 1'b0;
        n_cmp++; if (axi.awvalid !== 1'b1) begin n_bad++; $display("FAIL s1_awvalid: got %b want 1", axi.awvalid); end
        n_cmp++; if (axi.awaddr !== 32'h20) begin n_bad++; $display("FAIL s1_awaddr: got %h want 00000020", axi.awaddr); end
        n_cmp++; if (axi.awid !== 8'h03) begin n_bad++; $display("FAIL s1_awid: got %h want 03", axi.awid); end
        n_cmp++; if (axi.awlen !== 8'h00) begin n_bad++; $display("FAIL s1_awlen: got %h want 00", axi.awlen); end
        n_cmp++; if (axi.wvalid !== 1'b0) begin n_bad++; $display("FAIL s1_aw_w_overlap: got %b want 0", axi.wvalid); end
        step;
        n_cmp++; if (axi.awvalid !== 1'b0) begin n_bad++; $display("FAIL s1_awvalid_drop: got %b want 0", axi.awvalid); end
        n_cmp++; if (axi.wvalid !== 1'b1) begin n_bad++; $display("FAIL s1_wvalid: got %b want 1", axi.wvalid); end
        n_cmp++; if (axi.wlast !== 1'b1) begin n_bad++; $display("FAIL s1_wlast: got %b want 1", axi.wlast); end
        n_cmp++; if (axi.wdata[15:0] !== 16'hA5B5) begin n_bad++; $display("FAIL s1_lane0: got %h want a5b5", axi.wdata[15:0]); end
        n_cmp++; if (axi.wdata[31:16] !== 16'hA5B4) begin n_bad++; $display("FAIL s1_lane1: got %h want a5b4", axi.wdata[31:16]); end
        n_cmp++; if (axi.wdata !== 128'hA5B2A5B3_A5B0A5B1_A5B6A5B7_A5B4A5B5) begin n_bad++; $display("FAIL s1_wdata: got %h want a5b2a5b3a5b0a5b1a5b6a5b7a5b4a5b5", axi.wdata); end
        step;
        n_cmp++; if (axi.wvalid !== 1'b0) begin n_bad++; $display("FAIL s1_wvalid_drop: got %b want 0", axi.wvalid); end
        axi.bvalid = 1'b1;
        step;
        axi.bvalid = 1'b0;
        n_cmp++; if (write_done_p !== 1'b1) begin n_bad++; $display("FAIL s1_done: got %b want 1", write_done_p); end
        step;
        n_cmp++; if (write_done_p !== 1'b0) begin n_bad++; $display("FAIL s1_done_pulse: got %b want 0", write_done_p); end
        $display("burst addr=0000010 id=3 len=0 single-beat sequence done");
    endtask

    task automatic test_wready_stall;
        int nb, sb, cyc;
        bit to;
        logic [127:0] exp_lane0 [4];
        exp_lane0[0] = 128'(16'hA585);
        exp_lane0[1] = 128'(16'h4A62);
        exp_lane0[2] = 128'(16'h95A5);
        exp_lane0[3] = 128'(16'h2A12);
        do_reset;
        run_burst(28'h20, 4'd5, 4'd3, 1'b0, 1'b1, 2'b00, nb, sb, cyc, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout: got timeout want done within 200 cycles"); end
        n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL stall_beats: got %0d want 4", nb); end
        n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable stall cycles want 0", sb); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (128'(beat_data[k][15:0]) !== exp_lane0[k]) begin n_bad++; $display("FAIL stall_beat%0d_lane0: got %h want %h", k, beat_data[k][15:0], exp_lane0[k][15:0]); end
            n_cmp++; if (beat_last[k] !== (k == 3)) begin n_bad++; $display("FAIL stall_beat%0d_wlast: got %b want %b", k, beat_last[k], (k == 3)); end
        end
        n_cmp++; if (beat_data[3][127:112] !== 16'h2A15) begin n_bad++; $display("FAIL stall_beat3_lane7: got %h want 2a15", beat_data[3][127:112]); end
    endtask

    task automatic test_addr_wrap;
        int nb, sb, cyc;
        bit to;
        do_reset;
        run_burst(28'hFC, 4'd1, 4'd0, 1'b0, 1'b0, 2'b00, nb, sb, cyc, to);
        n_cmp++; if (to || nb !== 1) begin n_bad++; $display("FAIL wrap_beats: got %0d (timeout %0d) want 1", nb, to); end
        n_cmp++; if (beat_data[0][79:64] !== 16'hA5A5) begin n_bad++; $display("FAIL wrap_lane4: got %h want a5a5", beat_data[0][79:64]); end
        n_cmp++; if (beat_data[0][95:80] !== 16'hA5A4) begin n_bad++; $display("FAIL wrap_lane5: got %h want a5a4", beat_data[0][95:80]); end
        n_cmp++; if (beat_data[0][63:48] !== 16'hA55A) begin n_bad++; $display("FAIL wrap_lane3: got %h want a55a", beat_data[0][63:48]); end
    endtask

    task automatic test_pattern_01;
        int nb, sb, cyc;
        bit to;
        do_reset;
        run_burst(28'h40, 4'd2, 4'd1, 1'b1, 1'b0, 2'b00, nb, sb, cyc, to);
        n_cmp++; if (to || nb !== 2) begin n_bad++; $display("FAIL p01_beats: got %0d (timeout %0d) want 2", nb, to); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (beat_data[k] !== 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF) begin n_bad++; $display("FAIL p01_beat%0d: got %h want 0000ffff x4", k, beat_data[k]); end
        end
        // LFSR kept advancing through the fixed-pattern beats: A5 -> 4A -> 95
        run_burst(28'h10, 4'd2, 4'd0, 1'b0, 1'b0, 2'b00, nb, sb, cyc, to);
        n_cmp++; if (beat_data[0][15:0] !== 16'h9585) begin n_bad++; $display("FAIL p01_lfsr_persist: got %h want 9585", beat_data[0][15:0]); end
    endtask

    task automatic test_back_to_back;
        int nb, sb, cyc;
        bit to;
        do_reset;
        run_burst(28'h0, 4'd4, 4'd2, 1'b0, 1'b0, 2'b00, nb, sb, cyc, to);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL b2b_len2_cycles: got %0d want 6", cyc); end
        run_burst(28'h8, 4'd4, 4'd0, 1'b0, 1'b0, 2'b00, nb, sb, cyc, to);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL b2b_len0_cycles: got %0d want 4", cyc); end
        n_cmp++; if (beat_data[0][15:0] !== 16'h2A22) begin n_bad++; $display("FAIL b2b_second_lane0: got %h want 2a22", beat_data[0][15:0]); end
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        random_rw_addr = 28'h0; random_axi_id = 4'd1; random_axi_len = 4'd7;
        write_en = 1'b1;
        step;
        write_en = 1'b0;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        n_cmp++; if (axi.awvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_awvalid: got %b want 0", axi.awvalid); end
        n_cmp++; if (axi.wvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_wvalid: got %b want 0", axi.wvalid); end
        n_cmp++; if (axi.wlast !== 1'b0) begin n_bad++; $display("FAIL rmid_wlast: got %b want 0", axi.wlast); end
        random_rw_addr = 28'h10; random_axi_id = 4'd3; random_axi_len = 4'd0;
        axi.bid = 8'h03;
        write_en = 1'b1;
        step;
        write_en = 1'b0;
        n_cmp++; if (axi.awvalid !== 1'b1) begin n_bad++; $display("FAIL rmid_restart_awvalid: got %b want 1", axi.awvalid); end
        step;
        n_cmp++; if (axi.wdata[15:0] !== 16'hA5B5) begin n_bad++; $display("FAIL rmid_lfsr_seed: got %h want a5b5", axi.wdata[15:0]); end
        n_cmp++; if (axi.wlast !== 1'b1) begin n_bad++; $display("FAIL rmid_restart_wlast: got %b want 1", axi.wlast); end
        step;
        axi.bvalid = 1'b1;
        step;
        axi.bvalid = 1'b0;
        n_cmp++; if (write_done_p !== 1'b1) begin n_bad++; $display("FAIL rmid_done: got %b want 1", write_done_p); end
        $display("burst addr=0000000 id=1 len=7 interrupted by reset, restart done");
    endtask

    task automatic test_bresp_err;
        int nb, sb, cyc;
        bit to;
        int n_to = 0;
        logic [7:0] exp_one, exp_sat;
`ifdef TEST_WR_BRESP_CHK_EN
        exp_one = 8'h01; exp_sat = 8'hFF;
`else
        exp_one = 8'h00; exp_sat = 8'h00;
`endif
        do_reset;
        run_burst(28'h30, 4'd6, 4'd0, 1'b0, 1'b0, 2'b10, nb, sb, cyc, to);
        n_cmp++; if (wr_err_cnt !== exp_one) begin n_bad++; $display("FAIL err_after1: got %h want %h", wr_err_cnt, exp_one); end
        for (int k = 1; k < 300; k++) begin
            run_burst(28'(k), 4'(k), 4'd0, 1'b0, 1'b0, 2'b10, nb, sb, cyc, to);
            if (to) n_to++;
        end
        n_cmp++; if (n_to !== 0) begin n_bad++; $display("FAIL err_timeouts: got %0d want 0", n_to); end
        n_cmp++; if (wr_err_cnt !== exp_sat) begin n_bad++; $display("FAIL err_saturate: got %h want %h", wr_err_cnt, exp_sat); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_single_beat;
        test_wready_stall;
        test_addr_wrap;
        test_pattern_01;
        test_back_to_back;
        test_reset_mid_burst;
        test_bresp_err;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
